// File: rtl/lfsr5b_checker.sv
// lfsr5b_checker: self-seeding next-word predictor and lock/error monitor for the 5-bit LFSR stream.
// Latency: all flags registered, one cycle after the causing sample. Backpressure: none; samples taken whenever din_vld.
// Optional sequence-period meter enabled by defining LFSR_CHK_PERIOD_EN.
module lfsr5b_checker #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_ERR = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din_vld,
  input  logic [4:0]       din,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             zero_seen,
  output logic [4:0]       period,
  output logic             period_vld
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [2:0] LOCK_LAST   = 3'(LOCK_CNT - 1);
  localparam logic [2:0] UNLOCK_LAST = 3'(UNLOCK_ERR - 1);

  logic [1:0] state;
  logic [4:0] pred;
  logic [2:0] match_cnt;
  logic [2:0] miss_run;
  logic       lock_hit;

  function automatic logic [4:0] lfsr_next(input logic [4:0] x);
    return {x[3], x[2], x[1] ^ x[4], x[0], x[4]};
  endfunction

  // The sample that completes the run of matches; it is also the period reference word.
  assign lock_hit = !clr && din_vld && (state == VERIFY) && (din == pred) && (match_cnt == LOCK_LAST);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      pred      <= 5'd0;
      match_cnt <= 3'd0;
      miss_run  <= 3'd0;
      err       <= 1'b0;
      err_cnt   <= '0;
      zero_seen <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr) begin
        state     <= HUNT;
        match_cnt <= 3'd0;
        miss_run  <= 3'd0;
        err_cnt   <= '0;
        zero_seen <= 1'b0;
      end else if (din_vld) begin
        case (state)
          HUNT: begin
            if (din != 5'd0) begin
              pred      <= lfsr_next(din);
              match_cnt <= 3'd0;
              state     <= VERIFY;
            end else begin
              zero_seen <= 1'b1;
            end
          end
          VERIFY: begin
            if (din == pred) begin
              pred <= lfsr_next(din);
              if (lock_hit) begin
                state     <= LOCKED;
                match_cnt <= 3'd0;
                miss_run  <= 3'd0;
              end else begin
                match_cnt <= match_cnt + 3'd1;
              end
            end else if (din != 5'd0) begin
              pred      <= lfsr_next(din);
              match_cnt <= 3'd0;
            end else begin
              state     <= HUNT;
              zero_seen <= 1'b1;
            end
          end
          LOCKED: begin
            // Free-running prediction: a corrupted word must not become the new seed.
            pred <= lfsr_next(pred);
            if (din == pred) begin
              miss_run <= 3'd0;
            end else begin
              err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              if (miss_run == UNLOCK_LAST) begin
                state    <= HUNT;
                miss_run <= 3'd0;
              end else begin
                miss_run <= miss_run + 3'd1;
              end
            end
            if (din == 5'd0) zero_seen <= 1'b1;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef LFSR_CHK_PERIOD_EN
  logic [4:0] ref_word;
  logic [4:0] pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_word   <= 5'd0;
      pcnt       <= 5'd0;
      period     <= 5'd0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (lock_hit) begin
        ref_word <= pred;
        pcnt     <= 5'd0;
      end else if (!clr && din_vld && (state == LOCKED)) begin
        if (din == ref_word) begin
          period     <= pcnt + 5'd1;
          period_vld <= 1'b1;
          pcnt       <= 5'd0;
        end else begin
          pcnt <= pcnt + 5'd1;
        end
      end
    end
  end
`else
  assign period     = 5'd0;
  assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr5b_checker.sv
// Directed bench for lfsr5b_checker: lock, error, unlock/relock, zero word, clr, gaps, saturation, reset.
module tb_lfsr5b_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       din_vld;
  logic [4:0] din;

  logic       locked, err, zero_seen, period_vld;
  logic [7:0] err_cnt;
  logic [4:0] period;

  logic       locked_s, err_s, zero_seen_s, period_vld_s;
  logic [1:0] err_cnt_s;
  logic [4:0] period_s;

  int         nvec = 0;
  int         nbad = 0;
  int         errs;
  int         pulses;
  logic [4:0] gen;

  always #5 clk = ~clk;

  lfsr5b_checker dut (
    .clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld), .din(din),
    .locked(locked), .err(err), .err_cnt(err_cnt), .zero_seen(zero_seen),
    .period(period), .period_vld(period_vld)
  );

  lfsr5b_checker #(.ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .din_vld(din_vld), .din(din),
    .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s), .zero_seen(zero_seen_s),
    .period(period_s), .period_vld(period_vld_s)
  );

  function automatic logic [4:0] gen_next(input logic [4:0] x);
    return {x[3], x[2], x[1] ^ x[4], x[0], x[4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic v, input logic [4:0] d);
    @(negedge clk);
    clr = c; din_vld = v; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic good();
    step(1'b0, 1'b1, gen);
    gen = gen_next(gen);
  endtask

  task automatic bad();
    step(1'b0, 1'b1, gen ^ 5'h01);
    gen = gen_next(gen);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; din_vld = 1'b0; din = 5'd0; gen = 5'h1F;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_zero_seen", zero_seen, 0);
    chk("rst_period", period, 0);
    chk("rst_period_vld", period_vld, 0);
    chk("rst_err_cnt_s", err_cnt_s, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream from 1F: seed plus three matches
    repeat (3) good();
    chk("t1_not_locked_3", locked, 0);
    good();
    chk("t1_locked_4", locked, 1);
    errs = 0; pulses = 0;
    repeat (96) begin
      good();
      if (err) errs++;
      if (period_vld) pulses++;
    end
    chk("t1_no_err", errs, 0);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_still_locked", locked, 1);
`ifdef LFSR_CHK_PERIOD_EN
    chk("t1_period_pulses", pulses, 3);
    chk("t1_period", period, 31);
`else
    chk("t1_period_pulses", pulses, 0);
    chk("t1_period", period, 0);
`endif

    // Single corrupted word
    bad();
    chk("t2_err", err, 1);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_locked", locked, 1);
    good();
    chk("t2_err_pulse_end", err, 0);
    chk("t2_locked_after", locked, 1);

    // Two consecutive corrupted words drop lock
    bad();
    chk("t3_err_cnt_2", err_cnt, 2);
    chk("t3_locked_mid", locked, 1);
    bad();
    chk("t3_err", err, 1);
    chk("t3_err_cnt_3", err_cnt, 3);
    chk("t3_unlocked", locked, 0);
    errs = 0;
    repeat (3) begin
      good();
      if (err) errs++;
    end
    chk("t3_relock_3", locked, 0);
    good();
    chk("t3_relock_4", locked, 1);
    chk("t3_no_err_hunt", errs, 0);

    // clr wins over a valid sample; zero word in HUNT
    step(1'b1, 1'b1, gen);
    gen = gen_next(gen);
    chk("t4_clr_locked", locked, 0);
    chk("t4_clr_err_cnt", err_cnt, 0);
    chk("t4_clr_zero", zero_seen, 0);
    step(1'b0, 1'b1, 5'h00);
    chk("t4_zero_seen", zero_seen, 1);
    chk("t4_zero_hunt", locked, 0);
    step(1'b0, 1'b1, 5'h00);
    repeat (3) good();
    chk("t4_lock_3", locked, 0);
    good();
    chk("t4_lock_4", locked, 1);
    chk("t4_zero_sticky", zero_seen, 1);
    step(1'b1, 1'b0, 5'h00);
    chk("t4_clr2_zero", zero_seen, 0);
    chk("t4_clr2_err_cnt", err_cnt, 0);
    chk("t4_clr2_locked", locked, 0);

    // Gapped valid: idle cycles carry a zero word that must be ignored
    errs = 0;
    repeat (3) begin
      step(1'b0, 1'b0, 5'h00);
      good();
    end
    chk("t5_lock_3", locked, 0);
    step(1'b0, 1'b0, 5'h00);
    good();
    chk("t5_lock_4", locked, 1);
    repeat (20) begin
      step(1'b0, 1'b0, 5'h00);
      good();
      if (err) errs++;
    end
    chk("t5_no_err", errs, 0);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_zero_seen", zero_seen, 0);
    chk("t5_locked", locked, 1);

    // Mismatch while verifying never pulses err; then saturation with a 2-bit counter
    step(1'b1, 1'b0, 5'h00);
    good();
    bad();
    chk("t6_verify_no_err", err, 0);
    chk("t6_verify_unlocked", locked, 0);
    repeat (3) good();
    chk("t6_lock_3", locked, 0);
    good();
    chk("t6_lock_4", locked, 1);
    repeat (5) begin
      bad();
      good();
    end
    chk("t6_err_cnt_5", err_cnt, 5);
    chk("t6_err_cnt_sat", err_cnt_s, 3);
    chk("t6_locked", locked, 1);
    chk("t6_locked_s", locked_s, 1);

    // Asynchronous reset mid-stream, with a valid sample present
    @(negedge clk);
    din_vld = 1'b1; din = gen; rst = 1'b1;
    #1;
    chk("rst2_locked", locked, 0);
    chk("rst2_err_cnt", err_cnt, 0);
    chk("rst2_err_cnt_s", err_cnt_s, 0);
    @(posedge clk);
    #1;
    chk("rst2_hold_locked", locked, 0);
    chk("rst2_hold_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
